// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the 16-bit cellular RAM controller.
// Each 32-bit request becomes two ordered halfword transactions (low, then high).
module mem_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [31:0]       addr0_i,
    input  logic [31:0]       addr1_i,
    input  logic [31:0]       wdata0_i,
    input  logic [31:0]       wdata1_i,
    output logic [31:0]       rdata0_o,
    output logic [31:0]       rdata1_o,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic              err0_o,
    output logic              err1_o,
    output logic              stall0_o,
    output logic              mif_go_o,
    output logic              mif_we_o,
    output logic [ADDR_W-1:0] mif_addr_o,
    output logic [15:0]       mif_wdata_o,
    input  logic [15:0]       mif_rdata_i,
    input  logic              mif_done_i
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LO_GO   = 3'd1,
        ST_LO_WAIT = 3'd2,
        ST_HI_GO   = 3'd3,
        ST_HI_WAIT = 3'd4,
        ST_ACK     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                txn_we_q, txn_we_d;
    logic [ADDR_W-2:0]   txn_addr_q, txn_addr_d;
    logic [15:0]         txn_whi_q, txn_whi_d;
    logic [15:0]         lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0]          err_q, err_d;
    logic [31:0]         rdata0_q, rdata0_d;
    logic [31:0]         rdata1_q, rdata1_d;
    logic                mif_go_q, mif_go_d;
    logic                mif_we_q, mif_we_d;
    logic [ADDR_W-1:0]   mif_addr_q, mif_addr_d;
    logic [15:0]         mif_wdata_q, mif_wdata_d;

    logic                sel_s;
    logic                sel_we_s;
    logic [ADDR_W-2:0]   sel_addr_s;
    logic [31:0]         sel_wdata_s;
    logic                fin_s;
    logic                tmo_s;
    logic [31:0]         word_s;
    logic                unused_addr_s;

    // Only the halfword-relevant address bits reach the memory controller.
    assign unused_addr_s = ^{addr0_i[31:ADDR_W+1], addr0_i[1:0],
                             addr1_i[31:ADDR_W+1], addr1_i[1:0]};

    // Round-robin selection among the ports requesting in IDLE.
    always_comb begin
        sel_s = 1'b0;
        if (req0_i && req1_i) begin
            sel_s = ~last_grant_q;
        end else if (req1_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        if (sel_s) begin
            sel_we_s    = we1_i;
            sel_addr_s  = addr1_i[ADDR_W:2];
            sel_wdata_s = wdata1_i;
        end else begin
            sel_we_s    = we0_i;
            sel_addr_s  = addr0_i[ADDR_W:2];
            sel_wdata_s = wdata0_i;
        end
    end

    // Sequencer: next state, halfword issue and per-half timeout.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        txn_we_d     = txn_we_q;
        txn_addr_d   = txn_addr_q;
        txn_whi_d    = txn_whi_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
        mif_go_d     = 1'b0;
        mif_we_d     = mif_we_q;
        mif_addr_d   = mif_addr_q;
        mif_wdata_d  = mif_wdata_q;
        fin_s        = 1'b0;
        tmo_s        = 1'b0;
        word_s       = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    grant_d     = sel_s;
                    txn_we_d    = sel_we_s;
                    txn_addr_d  = sel_addr_s;
                    txn_whi_d   = sel_wdata_s[31:16];
                    lo_d        = 16'h0000;
                    mif_go_d    = 1'b1;
                    mif_we_d    = sel_we_s;
                    mif_addr_d  = {sel_addr_s, 1'b0};
                    mif_wdata_d = sel_wdata_s[15:0];
                    state_d     = ST_LO_GO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO_GO: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_LO_WAIT;
            end
            ST_LO_WAIT: begin
                if (mif_done_i) begin
                    if (txn_we_q) begin
                        lo_d = lo_q;
                    end else begin
                        lo_d = mif_rdata_i;
                    end
                    mif_go_d    = 1'b1;
                    mif_addr_d  = {txn_addr_q, 1'b1};
                    mif_wdata_d = txn_whi_q;
                    state_d     = ST_HI_GO;
                end else if (cnt_q == CNT_LAST) begin
                    fin_s   = 1'b1;
                    tmo_s   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HI_GO: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_HI_WAIT;
            end
            ST_HI_WAIT: begin
                if (mif_done_i) begin
                    fin_s   = 1'b1;
                    word_s  = {mif_rdata_i, lo_q};
                    state_d = ST_ACK;
                end else if (cnt_q == CNT_LAST) begin
                    fin_s   = 1'b1;
                    tmo_s   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ACK: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Completion: ack/err pulse and read-data load for the granted port.
    always_comb begin
        ack_d    = 2'b00;
        err_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (fin_s) begin
            if (grant_q) begin
                ack_d = 2'b10;
                err_d = {tmo_s, 1'b0};
            end else begin
                ack_d = 2'b01;
                err_d = {1'b0, tmo_s};
            end
            if (txn_we_q) begin
                rdata0_d = rdata0_q;
                rdata1_d = rdata1_q;
            end else if (grant_q) begin
                rdata1_d = word_s;
            end else begin
                rdata0_d = word_s;
            end
        end else begin
            ack_d = 2'b00;
        end
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            txn_we_q     <= 1'b0;
            txn_addr_q   <= {(ADDR_W-1){1'b0}};
            txn_whi_q    <= 16'h0000;
            lo_q         <= 16'h0000;
            cnt_q        <= {CNT_W{1'b0}};
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            rdata0_q     <= 32'h0000_0000;
            rdata1_q     <= 32'h0000_0000;
            mif_go_q     <= 1'b0;
            mif_we_q     <= 1'b0;
            mif_addr_q   <= {ADDR_W{1'b0}};
            mif_wdata_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            txn_we_q     <= txn_we_d;
            txn_addr_q   <= txn_addr_d;
            txn_whi_q    <= txn_whi_d;
            lo_q         <= lo_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            mif_go_q     <= mif_go_d;
            mif_we_q     <= mif_we_d;
            mif_addr_q   <= mif_addr_d;
            mif_wdata_q  <= mif_wdata_d;
        end
    end

    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign ack0_o      = ack_q[0];
    assign ack1_o      = ack_q[1];
    assign err0_o      = err_q[0];
    assign err1_o      = err_q[1];
    assign stall0_o    = req0_i & ~ack_q[0];
    assign mif_go_o    = mif_go_q;
    assign mif_we_o    = mif_we_q;
    assign mif_addr_o  = mif_addr_q;
    assign mif_wdata_o = mif_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a cycle-level model predicts grants, go strobes,
// acks and read data from the timing rules; a small memory answers the halfwords.
module tb_mem_arbiter;
    localparam int ADDR_W  = 26;
    localparam int TIMEOUT = 64;

    logic clk_i = 1'b0;
    logic rst_i;
    logic req0_i, req1_i, we0_i, we1_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
    logic [31:0] rdata0_o, rdata1_o;
    logic ack0_o, ack1_o, err0_o, err1_o, stall0_o;
    logic mif_go_o, mif_we_o;
    logic [ADDR_W-1:0] mif_addr_o;
    logic [15:0] mif_wdata_o, mif_rdata_i;
    logic mif_done_i;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .rdata0_o(rdata0_o), .rdata1_o(rdata1_o), .ack0_o(ack0_o), .ack1_o(ack1_o),
        .err0_o(err0_o), .err1_o(err1_o), .stall0_o(stall0_o),
        .mif_go_o(mif_go_o), .mif_we_o(mif_we_o), .mif_addr_o(mif_addr_o),
        .mif_wdata_o(mif_wdata_o), .mif_rdata_i(mif_rdata_i), .mif_done_i(mif_done_i)
    );

    // d = cycles from each go to its done; d = 0 means the memory never answers
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          d;
        int          gap;
    } txn_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] dev_mem [128];
    logic [15:0] ref_mem [128];
    txn_t pq [2][$];
    txn_t cur [2];
    bit   active [2];
    bit   busy;
    int   g_port, g_cyc, g_d, free_at;
    txn_t g_t;
    bit   last_grant;
    logic [31:0] g_word;
    logic [31:0] exp_rdata [2];
    int   ack_log [$];
    int   ack_k_log [$];
    int   go_count;
    bit   stray_en;

    function automatic logic [31:0] hw_of(input logic [31:0] a);
        return ((a >> 2) & ((32'h1 << (ADDR_W - 1)) - 32'h1)) << 1;
    endfunction

    task automatic model_reset();
        busy = 1'b0; free_at = cyc + 1; last_grant = 1'b1;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        active[0] = 1'b0; active[1] = 1'b0;
        pq[0].delete(); pq[1].delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req0_i = 1'b0; req1_i = 1'b0; mif_done_i = 1'b0;
        repeat (2) begin @(negedge clk_i); cyc++; end
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic push(input int p, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input int gap);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.d = d; t.gap = gap;
        pq[p].push_back(t);
    endtask

    // Runs queued transactions cycle by cycle against the timing model.
    task automatic run(input int budget);
        int n, k;
        bit exp_go, in_wait;
        logic [1:0] exp_ack, exp_err, got_ack;
        logic [31:0] hw;
        logic [15:0] exp_wd;
        logic [6:0] lo_i, hi_i;
        txn_t t;
        n = 0;
        forever begin
            if (!busy && !active[0] && !active[1] && pq[0].size() == 0 && pq[1].size() == 0) break;
            if (n >= budget) begin
                checks++; errors++;
                $display("FAIL run_budget: got %0d cycles, required completion within %0d", n, budget);
                break;
            end
            @(negedge clk_i); cyc++; n++;
            k = cyc - g_cyc;
            exp_go = busy && (k == 1 || (g_d > 0 && k == 2 + g_d));
            exp_ack = 2'b00;
            if (busy && ((g_d > 0 && k == 3 + 2 * g_d) || (g_d == 0 && k == 2 + TIMEOUT)))
                exp_ack[g_port] = 1'b1;
            exp_err = (g_d == 0) ? exp_ack : 2'b00;
            got_ack = {ack1_o, ack0_o};
            checks++;
            if (got_ack !== exp_ack) begin
                errors++; $display("FAIL ack cyc=%0d got=%b required=%b", cyc, got_ack, exp_ack);
            end
            checks++;
            if ({err1_o, err0_o} !== exp_err) begin
                errors++; $display("FAIL err cyc=%0d got=%b required=%b", cyc, {err1_o, err0_o}, exp_err);
            end
            checks++;
            if (mif_go_o !== exp_go) begin
                errors++; $display("FAIL go cyc=%0d got=%b required=%b", cyc, mif_go_o, exp_go);
            end
            if (mif_go_o === 1'b1) go_count++;
            if (exp_go) begin
                hw = hw_of(g_t.addr) + ((k == 1) ? 32'h0 : 32'h1);
                exp_wd = (k == 1) ? g_t.wdata[15:0] : g_t.wdata[31:16];
                checks++;
                if (mif_addr_o !== hw[ADDR_W-1:0] || mif_we_o !== g_t.we || mif_wdata_o !== exp_wd) begin
                    errors++;
                    $display("FAIL go_fields cyc=%0d got addr=%h we=%b wd=%h required addr=%h we=%b wd=%h",
                             cyc, mif_addr_o, mif_we_o, mif_wdata_o, hw[ADDR_W-1:0], g_t.we, exp_wd);
                end
            end
            for (int i = 0; i < 2; i++) if (got_ack[i] === 1'b1) ack_log.push_back(i);
            if (exp_ack != 2'b00) begin
                if (!g_t.we) exp_rdata[g_port] = g_word;
                checks++;
                if (rdata0_o !== exp_rdata[0] || rdata1_o !== exp_rdata[1]) begin
                    errors++;
                    $display("FAIL rdata cyc=%0d got %h/%h required %h/%h",
                             cyc, rdata0_o, rdata1_o, exp_rdata[0], exp_rdata[1]);
                end
                ack_k_log.push_back(k);
                busy = 1'b0; free_at = cyc + 1; last_grant = g_port[0]; active[g_port] = 1'b0;
            end
            // memory side: real done at the end of each wait, stray done elsewhere
            in_wait = busy && ((g_d > 0 && ((k >= 2 && k <= 1 + g_d) || (k >= 3 + g_d && k <= 2 + 2 * g_d)))
                               || (g_d == 0 && k >= 2 && k <= 1 + TIMEOUT));
            mif_done_i = 1'b0;
            mif_rdata_i = 16'($urandom);
            if (busy && g_d > 0 && (k == 1 + g_d || k == 2 + 2 * g_d)) begin
                if (mif_we_o) dev_mem[mif_addr_o[6:0]] = mif_wdata_o;
                else mif_rdata_i = dev_mem[mif_addr_o[6:0]];
                mif_done_i = 1'b1;
            end else if (stray_en && !in_wait) begin
                mif_done_i = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (!active[p] && pq[p].size() > 0) begin
                    t = pq[p][0];
                    if (t.gap > 0) begin t.gap--; pq[p][0] = t; end
                    else begin cur[p] = pq[p].pop_front(); active[p] = 1'b1; end
                end
            end
            req0_i = active[0];
            we0_i = active[0] ? cur[0].we : 1'($urandom);
            addr0_i = active[0] ? cur[0].addr : $urandom;
            wdata0_i = active[0] ? cur[0].wdata : $urandom;
            req1_i = active[1];
            we1_i = active[1] ? cur[1].we : 1'($urandom);
            addr1_i = active[1] ? cur[1].addr : $urandom;
            wdata1_i = active[1] ? cur[1].wdata : $urandom;
            if (!busy && cyc >= free_at && (active[0] || active[1])) begin
                if (active[0] && active[1]) g_port = last_grant ? 0 : 1;
                else g_port = active[1] ? 1 : 0;
                g_t = cur[g_port]; g_d = g_t.d; g_cyc = cyc; busy = 1'b1;
                hw = hw_of(g_t.addr); lo_i = hw[6:0]; hi_i = lo_i + 7'd1;
                g_word = 32'h0;
                if (g_d > 0 && g_t.we) begin
                    ref_mem[lo_i] = g_t.wdata[15:0]; ref_mem[hi_i] = g_t.wdata[31:16];
                end else if (g_d > 0) begin
                    g_word = {ref_mem[hi_i], ref_mem[lo_i]};
                end
            end
            #1;
            checks++;
            if (stall0_o !== (req0_i & ~exp_ack[0])) begin
                errors++; $display("FAIL stall0 cyc=%0d got=%b required=%b", cyc, stall0_o, req0_i & ~exp_ack[0]);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #3;
        checks++;
        if ({ack0_o, ack1_o, err0_o, err1_o, mif_go_o, mif_we_o, stall0_o} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got=%b required=0", {ack0_o, ack1_o, err0_o, err1_o, mif_go_o, mif_we_o, stall0_o});
        end
        checks++;
        if (rdata0_o !== 32'h0 || rdata1_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got=%h/%h required 0/0", rdata0_o, rdata1_o);
        end
        checks++;
        if (mif_addr_o !== '0 || mif_wdata_o !== 16'h0) begin
            errors++; $display("FAIL reset_mif got addr=%h wd=%h required 0", mif_addr_o, mif_wdata_o);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        dev_mem[8] = 16'hBEEF; ref_mem[8] = 16'hBEEF;
        dev_mem[9] = 16'hDEAD; ref_mem[9] = 16'hDEAD;
        ack_k_log.delete();
        push(0, 1'b0, 32'h0000_0010, $urandom, 2, 0);
        run(100);
        checks++;
        if (ack_k_log.size() != 1 || ack_k_log[0] != 7) begin
            errors++; $display("FAIL read_ack_cycle got=%0d required=7", (ack_k_log.size() > 0) ? ack_k_log[0] : -1);
        end
        checks++;
        if (rdata0_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_word got=%h required=deadbeef", rdata0_o);
        end
    endtask

    task automatic test_write();
        dev_mem[32] = 16'hA5A5; ref_mem[32] = 16'hA5A5;
        dev_mem[33] = 16'h5A5A; ref_mem[33] = 16'h5A5A;
        push(1, 1'b0, 32'h0000_0040, $urandom, 1, 0);
        push(1, 1'b1, 32'h0000_0040, 32'h1234_5678, 2, 1);
        run(100);
        checks++;
        if (dev_mem[32] !== 16'h5678 || dev_mem[33] !== 16'h1234) begin
            errors++; $display("FAIL write_mem got=%h_%h required=1234_5678", dev_mem[33], dev_mem[32]);
        end
        checks++;
        if (rdata1_o !== 32'h5A5A_A5A5) begin
            errors++; $display("FAIL write_rdata_hold got=%h required=5a5aa5a5", rdata1_o);
        end
    endtask

    task automatic test_tie();
        do_reset();
        ack_log.delete();
        for (int i = 0; i < 2; i++) begin
            push(0, 1'($urandom), {24'h0, 8'($urandom)}, $urandom, $urandom_range(1, 3), 0);
            push(1, 1'($urandom), {24'h0, 8'($urandom)}, $urandom, $urandom_range(1, 3), 0);
        end
        run(200);
        checks++;
        if (ack_log.size() != 4 || ack_log[0] != 0 || ack_log[1] != 1 || ack_log[2] != 0 || ack_log[3] != 1) begin
            errors++; $display("FAIL tie_order got %p required 0,1,0,1", ack_log);
        end
    endtask

    task automatic test_timeout();
        ack_k_log.delete();
        go_count = 0;
        push(0, 1'b0, 32'h0000_0080, $urandom, 1, 0);
        push(0, 1'b0, 32'h0000_0084, $urandom, 0, 0);
        push(0, 1'b0, 32'h0000_0088, $urandom, 2, 0);
        run(300);
        checks++;
        if (ack_k_log.size() != 3 || ack_k_log[1] != 66) begin
            errors++; $display("FAIL timeout_cycle got=%0d required=66", (ack_k_log.size() > 1) ? ack_k_log[1] : -1);
        end
        checks++;
        if (go_count != 5) begin
            errors++; $display("FAIL timeout_gos got=%0d required=5", go_count);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i); cyc++;
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'h0000_0020; wdata0_i = 32'h0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i); cyc++;
            mif_done_i = (c == 3); mif_rdata_i = 16'h1111;
            if (c == 4) begin
                checks++;
                if (mif_go_o !== 1'b1 || mif_addr_o !== 26'h11) begin
                    errors++; $display("FAIL mid_hi_go got go=%b addr=%h required go=1 addr=11", mif_go_o, mif_addr_o);
                end
            end
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({ack0_o, ack1_o, err0_o, err1_o, mif_go_o, mif_we_o} !== 6'b0 || rdata0_o !== 32'h0 ||
            rdata1_o !== 32'h0 || mif_addr_o !== '0 || mif_wdata_o !== 16'h0) begin
            errors++; $display("FAIL mid_reset_outputs got rd0=%h rd1=%h addr=%h go=%b required all 0",
                               rdata0_o, rdata1_o, mif_addr_o, mif_go_o);
        end
        @(negedge clk_i); cyc++;
        rst_i = 1'b0; req0_i = 1'b0; mif_done_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i); cyc++;
            mif_done_i = 1'b0;
            checks++;
            if ({ack0_o, ack1_o, mif_go_o} !== 3'b000) begin
                errors++; $display("FAIL mid_no_ack got ack0=%b ack1=%b go=%b required 0", ack0_o, ack1_o, mif_go_o);
            end
        end
        model_reset();
        push(0, 1'b0, 32'h0000_0024, $urandom, 1, 0);
        run(50);
    endtask

    task automatic test_stray();
        dev_mem[48] = 16'hC0DE; ref_mem[48] = 16'hC0DE;
        dev_mem[49] = 16'hF00D; ref_mem[49] = 16'hF00D;
        stray_en = 1'b1;
        push(0, 1'b0, 32'h0000_0060, $urandom, 5, 3);
        run(100);
        stray_en = 1'b0;
        checks++;
        if (rdata0_o !== 32'hF00D_C0DE) begin
            errors++; $display("FAIL stray_word got=%h required=f00dc0de", rdata0_o);
        end
    endtask

    task automatic test_random();
        int d;
        for (int pass = 0; pass < 2; pass++) begin
            stray_en = pass[0];
            for (int i = 0; i < 40; i++) begin
                d = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4);
                push($urandom_range(0, 1), 1'($urandom),
                     {5'($urandom), 19'h0, 8'($urandom)}, $urandom, d, $urandom_range(0, 3));
            end
            run(6000);
        end
        stray_en = 1'b0;
        for (int a = 0; a < 256; a += 4) push(a % 2, 1'b0, a, $urandom, 1, 0);
        run(3000);
    endtask

    initial begin
        req0_i = 1'b0; req1_i = 1'b0; we0_i = 1'b0; we1_i = 1'b0;
        addr0_i = 32'h0; addr1_i = 32'h0; wdata0_i = 32'h0; wdata1_i = 32'h0;
        mif_rdata_i = 16'h0; mif_done_i = 1'b0; stray_en = 1'b0; go_count = 0;
        g_cyc = 0; g_d = 1; g_port = 0;
        for (int i = 0; i < 128; i++) begin
            dev_mem[i] = 16'($urandom) | 16'h0001;
            ref_mem[i] = dev_mem[i];
        end
        model_reset();
        test_reset();
        test_single_read();
        test_write();
        test_tie();
        test_timeout();
        test_reset_mid();
        test_stray();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
